// File: rtl/myo_spi_sequencer.sv
// Round-robin SPI frame sequencer: streams per-motor command words to a shared SPI
// master and captures the returned status words into a per-motor status bank.
module myo_spi_sequencer #(
  parameter int NUM_MOTORS   = 8,
  parameter int CMD_WORDS    = 5,
  parameter int STATUS_WORDS = 7,
  parameter int ACK_TIMEOUT  = 1023,
  localparam int MW = $clog2(NUM_MOTORS)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [NUM_MOTORS-1:0] enable_mask,
  input  logic                  di_req,
  input  logic                  write_ack,
  input  logic                  data_read_valid,
  input  logic [15:0]           data_read,
  input  logic                  ss_n,
  output logic [NUM_MOTORS-1:0] ss_n_o,
  output logic [15:0]           Word,
  output logic                  wren,
  output logic                  spi_done,
  output logic                  frame_done,
  output logic [MW-1:0]         cur_motor,
  input  logic                  cmd_we,
  input  logic [MW-1:0]         cmd_motor,
  input  logic [3:0]            cmd_index,
  input  logic [15:0]           cmd_data,
  input  logic [MW-1:0]         stat_motor,
  input  logic [3:0]            stat_index,
  output logic [15:0]           stat_data,
  output logic [NUM_MOTORS-1:0] timeout_err,
  input  logic [NUM_MOTORS-1:0] err_clr
);

  localparam int FRAME_WORDS = CMD_WORDS + STATUS_WORDS;
  localparam int CIW = $clog2(NUM_MOTORS * CMD_WORDS);
  localparam int SIW = $clog2(NUM_MOTORS * STATUS_WORDS);
  localparam logic [15:0] WD_LAST = 16'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SELECT, LOAD, WAIT_ACK, WAIT_END} state_t;

  state_t                state_q, state_d;
  logic [5:0]            word_cnt_q, word_cnt_d;
  logic [5:0]            rx_cnt_q, rx_cnt_d, rx_base;
  logic [15:0]           wd_q, wd_d;
  logic [MW-1:0]         cur_motor_q, cur_motor_d, next_motor, cand;
  logic [15:0]           word_q, word_d;
  logic                  wren_q, wren_d;
  logic                  spi_done_q, spi_done_d;
  logic                  frame_done_q, frame_done_d;
  logic                  ack_prev_q, ack_edge;
  logic [NUM_MOTORS-1:0] err_q, err_set;
  logic [15:0]           stat_data_q;
  logic [15:0]           cmd_q    [NUM_MOTORS*CMD_WORDS];
  logic [15:0]           status_q [NUM_MOTORS*STATUS_WORDS];
  logic [CIW-1:0]        cmd_rd_idx, cmd_wr_idx;
  logic [SIW-1:0]        stat_wr_idx, stat_rd_idx;
  logic                  cmd_wr_en, cap_en, stat_rd_ok;

  assign ack_edge    = write_ack & ~ack_prev_q;
  assign cmd_rd_idx  = CIW'(int'(cur_motor_q) * CMD_WORDS + int'(word_cnt_q));
  assign cmd_wr_idx  = CIW'(int'(cmd_motor) * CMD_WORDS + int'(cmd_index));
  assign cmd_wr_en   = cmd_we && (int'(cmd_index) < CMD_WORDS) && (int'(cmd_motor) < NUM_MOTORS);
  assign stat_rd_idx = SIW'(int'(stat_motor) * STATUS_WORDS + int'(stat_index));
  assign stat_rd_ok  = (int'(stat_motor) < NUM_MOTORS) && (int'(stat_index) < STATUS_WORDS);

  // Receive counter restarts in SELECT, yet a strobe landing in SELECT still counts.
  assign rx_base     = (state_q == SELECT) ? 6'd0 : rx_cnt_q;
  assign cap_en      = data_read_valid && (state_q != IDLE) &&
                       (int'(rx_base) >= CMD_WORDS) && (int'(rx_base) < FRAME_WORDS);
  assign stat_wr_idx = SIW'(int'(cur_motor_q) * STATUS_WORDS + int'(rx_base) - CMD_WORDS);

  // Walk downwards so the nearest enabled motor after cur_motor wins; i == NUM_MOTORS
  // lands back on cur_motor itself, covering the single-enabled case.
  always_comb begin
    next_motor = cur_motor_q;
    cand       = '0;
    for (int i = NUM_MOTORS; i >= 1; i--) begin
      cand = MW'((int'(cur_motor_q) + i) % NUM_MOTORS);
      if (enable_mask[cand]) next_motor = cand;
    end
  end

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    wd_d         = wd_q;
    cur_motor_d  = cur_motor_q;
    word_d       = word_q;
    wren_d       = wren_q;
    spi_done_d   = spi_done_q;
    frame_done_d = 1'b0;
    err_set      = '0;
    rx_cnt_d     = rx_base;
    if (data_read_valid && (state_q != IDLE) && (int'(rx_base) < FRAME_WORDS))
      rx_cnt_d = rx_base + 6'd1;
    case (state_q)
      IDLE: begin
        spi_done_d = 1'b1;
        if ((start || continuous) && (enable_mask != '0) && ss_n) begin
          spi_done_d = 1'b0;
          state_d    = SELECT;
        end
      end
      SELECT: begin
        cur_motor_d = next_motor;
        word_cnt_d  = '0;
        wd_d        = '0;
        state_d     = LOAD;
      end
      LOAD: begin
        if (word_cnt_q != '0) wd_d = wd_q + 16'd1;
        if ((word_cnt_q == '0) || di_req) begin
          word_d  = (int'(word_cnt_q) < CMD_WORDS) ? cmd_q[cmd_rd_idx] : 16'h0000;
          wren_d  = 1'b1;
          state_d = WAIT_ACK;
        end else if (wd_q == WD_LAST) begin
          err_set[cur_motor_q] = 1'b1;
          wren_d               = 1'b0;
          state_d              = WAIT_END;
        end
      end
      WAIT_ACK: begin
        if (ack_edge) begin
          wren_d     = 1'b0;
          wd_d       = '0;
          word_cnt_d = word_cnt_q + 6'd1;
          state_d    = (int'(word_cnt_q) + 1 == FRAME_WORDS) ? WAIT_END : LOAD;
        end else if (wd_q == WD_LAST) begin
          err_set[cur_motor_q] = 1'b1;
          wren_d               = 1'b0;
          state_d              = WAIT_END;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      WAIT_END: begin
        if (ss_n) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      rx_cnt_q     <= '0;
      wd_q         <= '0;
      cur_motor_q  <= MW'(NUM_MOTORS - 1);
      word_q       <= '0;
      wren_q       <= 1'b0;
      spi_done_q   <= 1'b1;
      frame_done_q <= 1'b0;
      ack_prev_q   <= 1'b0;
      err_q        <= '0;
      stat_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      rx_cnt_q     <= rx_cnt_d;
      wd_q         <= wd_d;
      cur_motor_q  <= cur_motor_d;
      word_q       <= word_d;
      wren_q       <= wren_d;
      spi_done_q   <= spi_done_d;
      frame_done_q <= frame_done_d;
      ack_prev_q   <= write_ack;
      err_q        <= (err_q & ~err_clr) | err_set;
      stat_data_q  <= stat_rd_ok ? status_q[stat_rd_idx] : 16'h0000;
    end
  end

  // Word 0 of every motor holds the start-of-frame marker out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_MOTORS * CMD_WORDS; i++)
        cmd_q[i] <= ((i % CMD_WORDS) == 0) ? 16'h8000 : 16'h0000;
    end else if (cmd_wr_en) begin
      cmd_q[cmd_wr_idx] <= cmd_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_MOTORS * STATUS_WORDS; i++)
        status_q[i] <= 16'h0000;
    end else if (cap_en) begin
      status_q[stat_wr_idx] <= data_read;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MOTORS; gi++) begin : g_ss
      assign ss_n_o[gi] = (cur_motor_q == MW'(gi)) ? ss_n : 1'b1;
    end
  endgenerate

  assign Word        = word_q;
  assign wren        = wren_q;
  assign spi_done    = spi_done_q;
  assign frame_done  = frame_done_q;
  assign cur_motor   = cur_motor_q;
  assign stat_data   = stat_data_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_myo_spi_sequencer.sv
// Bench for myo_spi_sequencer: a small SPI-master model acks each word, while expected
// tx words and motors are queued at start time and popped as the DUT presents them.
`timescale 1ns/1ps
module tb_myo_spi_sequencer;

  localparam int NM = 8;
  localparam int FW = 12;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic [NM-1:0] enable_mask = '0;
  logic          di_req = 1'b0;
  logic          write_ack = 1'b0;
  logic          data_read_valid = 1'b0;
  logic [15:0]   data_read = '0;
  logic          ss_n = 1'b1;
  logic [NM-1:0] ss_n_o;
  logic [15:0]   Word;
  logic          wren, spi_done, frame_done;
  logic [2:0]    cur_motor;
  logic          cmd_we = 1'b0;
  logic [2:0]    cmd_motor = '0;
  logic [3:0]    cmd_index = '0;
  logic [15:0]   cmd_data = '0;
  logic [2:0]    stat_motor = '0;
  logic [3:0]    stat_index = '0;
  logic [15:0]   stat_data;
  logic [NM-1:0] timeout_err;
  logic [NM-1:0] err_clr = '0;

  int checks_total = 0;
  int checks_passed = 0;
  logic [15:0] exp_word_q[$];
  int          exp_motor_q[$];

  always #5 clock = ~clock;

  myo_spi_sequencer #(
    .NUM_MOTORS(8), .CMD_WORDS(5), .STATUS_WORDS(7), .ACK_TIMEOUT(16)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .continuous(continuous),
    .enable_mask(enable_mask), .di_req(di_req), .write_ack(write_ack),
    .data_read_valid(data_read_valid), .data_read(data_read), .ss_n(ss_n),
    .ss_n_o(ss_n_o), .Word(Word), .wren(wren), .spi_done(spi_done),
    .frame_done(frame_done), .cur_motor(cur_motor), .cmd_we(cmd_we),
    .cmd_motor(cmd_motor), .cmd_index(cmd_index), .cmd_data(cmd_data),
    .stat_motor(stat_motor), .stat_index(stat_index), .stat_data(stat_data),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic expect_frame(input int motor, input logic [15:0] w1);
    exp_motor_q.push_back(motor);
    for (int i = 0; i < FW; i++)
      exp_word_q.push_back(i == 0 ? 16'h8000 : (i == 1 ? w1 : 16'h0000));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_wren();
    int guard = 0;
    while (wren !== 1'b1 && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    if (wren !== 1'b1) check_val("wren_wait", {31'd0, wren}, 32'd1);
  endtask

  // Acks 'acks' words; a full frame is then closed by raising ss_n.
  task automatic serve_frame(input int acks, input logic [15:0] rx_first, input bit stop_cont);
    logic [15:0] exp_w;
    int motor;
    motor  = (exp_motor_q.size() > 0) ? exp_motor_q.pop_front() : -1;
    di_req = 1'b1;
    for (int n = 0; n < acks; n++) begin
      wait_wren();
      if (wren !== 1'b1) break;
      exp_w = (exp_word_q.size() > 0) ? exp_word_q.pop_front() : 16'hDEAD;
      check_val($sformatf("word%0d_m%0d", n, motor), {16'd0, Word}, {16'd0, exp_w});
      if (n == 0) begin
        ss_n = 1'b0;
        #1;
        check_val("cur_motor", {29'd0, cur_motor}, motor);
        check_val("ss_n_o", {24'd0, ss_n_o}, {24'd0, ~(8'h01 << motor)});
      end
      write_ack       = 1'b1;
      data_read_valid = 1'b1;
      data_read       = rx_first + 16'(n);
      @(negedge clock);
      check_val("wren_drop", {31'd0, wren}, 32'd0);
      write_ack       = 1'b0;
      data_read_valid = 1'b0;
    end
    if (acks == FW) begin
      if (stop_cont) continuous = 1'b0;
      ss_n = 1'b1;
      @(negedge clock);
      check_val("frame_done", {31'd0, frame_done}, 32'd1);
      @(negedge clock);
      check_val("frame_done_pulse", {31'd0, frame_done}, 32'd0);
      $display("frame motor=%0d words=%0d", motor, acks);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    bit wren_seen;
    bit done_low;

    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_val("rst_wren", {31'd0, wren}, 32'd0);
    check_val("rst_spi_done", {31'd0, spi_done}, 32'd1);
    check_val("rst_cur_motor", {29'd0, cur_motor}, 32'd7);
    check_val("rst_err", {24'd0, timeout_err}, 32'd0);
    check_val("rst_word", {16'd0, Word}, 32'd0);

    // Default banks, all motors enabled: motor 0 first, start-to-wren latency.
    enable_mask = 8'hFF;
    expect_frame(0, 16'h0000);
    pulse_start();
    check_val("spi_done_clr", {31'd0, spi_done}, 32'd0);
    @(negedge clock);
    check_val("lat_t2_wren", {31'd0, wren}, 32'd0);
    @(negedge clock);
    check_val("lat_t3_wren", {31'd0, wren}, 32'd1);
    serve_frame(FW, 16'd0, 1'b0);
    check_val("spi_done_end", {31'd0, spi_done}, 32'd1);
    check_val("cur_motor_end", {29'd0, cur_motor}, 32'd0);

    // Continuous round-robin over a sparse mask.
    enable_mask = 8'b1010_0100;
    continuous  = 1'b1;
    expect_frame(2, 16'h0000);
    expect_frame(5, 16'h0000);
    expect_frame(7, 16'h0000);
    expect_frame(2, 16'h0000);
    for (int f = 0; f < 4; f++) serve_frame(FW, 16'd0, f == 3);
    check_val("cont_idle", {31'd0, spi_done}, 32'd1);

    // Custom command word and status capture on motor 3.
    cmd_we = 1'b1; cmd_motor = 3'd3; cmd_index = 4'd1; cmd_data = 16'd500;
    @(negedge clock);
    cmd_we = 1'b0;
    enable_mask = 8'b0000_1000;
    expect_frame(3, 16'd500);
    pulse_start();
    serve_frame(FW, 16'd1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      stat_motor = 3'd3; stat_index = 4'(i);
      @(negedge clock);
      check_val($sformatf("status3_%0d", i), {16'd0, stat_data}, 32'(6 + i));
    end
    stat_motor = 3'd3; stat_index = 4'd7;
    @(negedge clock);
    check_val("status_oor", {16'd0, stat_data}, 32'd0);
    stat_motor = 3'd2; stat_index = 4'd0;
    @(negedge clock);
    check_val("status2_0", {16'd0, stat_data}, 32'd5);

    // Watchdog: ack two words, then withhold the third ack.
    expect_frame(3, 16'd500);
    pulse_start();
    serve_frame(2, 16'd0, 1'b0);
    wait_wren();
    check_val("wd_word2", {16'd0, Word}, {16'd0, exp_word_q.pop_front()});
    exp_word_q.delete();
    k = 0;
    while (timeout_err[3] !== 1'b1 && k < 40) begin
      @(negedge clock);
      k++;
    end
    check_val("wd_cycles", k, 32'd15);
    check_val("wd_err", {24'd0, timeout_err}, 32'h08);
    check_val("wd_wren", {31'd0, wren}, 32'd0);
    ss_n = 1'b1;
    @(negedge clock);
    check_val("wd_frame_done", {31'd0, frame_done}, 32'd1);
    $display("frame motor=3 aborted by watchdog");
    err_clr = 8'h08;
    @(negedge clock);
    err_clr = 8'h00;
    check_val("wd_err_clr", {24'd0, timeout_err}, 32'd0);

    // Reset in the middle of a frame to motor 4.
    enable_mask = 8'hFF;
    expect_frame(4, 16'h0000);
    pulse_start();
    serve_frame(3, 16'd0, 1'b0);
    wait_wren();
    #2;
    reset_n = 1'b0;
    #1;
    check_val("rst_mid_wren", {31'd0, wren}, 32'd0);
    check_val("rst_mid_spi_done", {31'd0, spi_done}, 32'd1);
    check_val("rst_mid_cur", {29'd0, cur_motor}, 32'd7);
    exp_word_q.delete();
    exp_motor_q.delete();
    ss_n = 1'b1; write_ack = 1'b0; data_read_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    stat_motor = 3'd3; stat_index = 4'd0;
    @(negedge clock);
    check_val("rst_status", {16'd0, stat_data}, 32'd0);
    $display("reset applied mid-frame");
    expect_frame(0, 16'h0000);
    pulse_start();
    serve_frame(FW, 16'd0, 1'b0);

    // Empty mask with start held: the sequencer must stay idle.
    enable_mask = 8'h00;
    start       = 1'b1;
    wren_seen   = 1'b0;
    done_low    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (wren === 1'b1) wren_seen = 1'b1;
      if (spi_done !== 1'b1) done_low = 1'b1;
    end
    start = 1'b0;
    check_val("mask0_wren", {31'd0, wren_seen}, 32'd0);
    check_val("mask0_spi_done", {31'd0, done_low}, 32'd0);
    $display("mask=0 start held 20 cycles");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/myo_spi_sequencer.md
# myo_spi_sequencer

Parametrised SPI frame sequencer for up to 16 motor boards sharing one SPI master core. It holds a per-motor bank of command words and a per-motor bank of status words. Each frame it selects the next enabled motor in round-robin order, streams that motor's command words to the master, and captures the returned status words into that motor's status bank. Added behaviour: a motor enable mask, continuous mode, and an ack watchdog with sticky per-motor error flags. It sits between the host register interface and the SPI master.

## Interface
Parameters:
- NUM_MOTORS, 8: motor count, 2..16; MW = $clog2(NUM_MOTORS)
- CMD_WORDS, 5: command words per frame, 1..16; word 0 is the start-of-frame word
- STATUS_WORDS, 7: status words per frame, 1..16; FRAME_WORDS = CMD_WORDS + STATUS_WORDS
- ACK_TIMEOUT, 1023: watchdog limit in cycles, 1..65535

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request one frame (level, sampled in IDLE)
- continuous  in  1  1 = start the next frame automatically
- enable_mask  in  NUM_MOTORS  motors included in round-robin
- di_req  in  1  master requests the next tx word
- write_ack  in  1  master accepted Word (rising edge counts)
- data_read_valid  in  1  data_read valid, one-cycle strobe
- data_read  in  16  received word
- ss_n  in  1  slave select from the master
- ss_n_o  out  NUM_MOTORS  gated per-motor slave selects
- Word  out  16  tx word to the master
- wren  out  1  tx word write enable
- spi_done  out  1  sequencer idle
- frame_done  out  1  one-cycle pulse at frame end
- cur_motor  out  MW  motor of the current or last frame
- cmd_we, cmd_motor[MW], cmd_index[4], cmd_data[16]  in  host command write port
- stat_motor[MW], stat_index[4]  in  status read address
- stat_data  out  16  registered status read data
- timeout_err  out  NUM_MOTORS  sticky watchdog flags
- err_clr  in  NUM_MOTORS  clear flags, bitwise

## Operation
- Reset values:
  - FSM = IDLE; Word = 0; wren = 0; spi_done = 1; frame_done = 0.
  - cur_motor = NUM_MOTORS-1, so motor 0 is served first.
  - timeout_err = 0; stat_data = 0; status bank = 0.
  - Command word 0 of every motor = 16'h8000; all other command words = 0.
- States: IDLE, SELECT, LOAD, WAIT_ACK, WAIT_END.
- IDLE:
  - spi_done = 1.
  - If (start or continuous) and enable_mask != 0 and ss_n == 1: go to SELECT and clear spi_done.
  - If enable_mask == 0, stay in IDLE.
- SELECT:
  - cur_motor = first enabled motor strictly after cur_motor, wrapping modulo NUM_MOTORS.
  - If only one motor is enabled, it is reselected.
  - Clear word_cnt, rx_cnt and the watchdog; go to LOAD.
- LOAD:
  - Proceed when word_cnt == 0 or di_req == 1.
  - If word_cnt < CMD_WORDS, Word = cmd[cur_motor][word_cnt]; otherwise Word = 0.
  - Set wren = 1; go to WAIT_ACK.
- WAIT_ACK:
  - On a write_ack rising edge (write_ack_prev == 0, write_ack == 1): wren = 0 and word_cnt++.
  - If the incremented word_cnt == FRAME_WORDS, go to WAIT_END; otherwise go to LOAD.
- Watchdog:
  - Counts in LOAD when word_cnt > 0, and in WAIT_ACK; clears on every ack.
  - When it reaches ACK_TIMEOUT: set timeout_err[cur_motor], wren = 0, go to WAIT_END (frame aborted).
- Receive capture, in SELECT through WAIT_END:
  - Each data_read_valid increments rx_cnt.
  - If CMD_WORDS <= rx_cnt < FRAME_WORDS, status[cur_motor][rx_cnt-CMD_WORDS] = data_read.
  - All other strobes are ignored.
- WAIT_END:
  - When ss_n == 1: frame_done pulses for one cycle; go to IDLE.
- Slave select: ss_n_o[m] = (m == cur_motor) ? ss_n : 1.
- Command port:
  - Writes with cmd_index >= CMD_WORDS or cmd_motor >= NUM_MOTORS are ignored.
  - A write in the same cycle as a LOAD of that word: Word takes the old value; the new value is used from the next frame.
- Status port:
  - stat_data = status[stat_motor][stat_index], one cycle after the address.
  - Out-of-range address returns 0.
- Error flags: err_clr[m] clears timeout_err[m]. If a set and a clear hit the same bit in the same cycle, the set wins.
- Busy behaviour: start outside IDLE is ignored. Changes to enable_mask take effect at the next SELECT; the current frame completes.

## Timing
- start high in IDLE at cycle T:
  - SELECT at T+1, LOAD at T+2.
  - Word and wren valid from T+3.
- Ack to next word:
  - Ack edge at cycle A: wren low from A+1.
  - If di_req is already high, the next Word and wren = 1 arrive at A+2.
- Frame end: frame_done is high the cycle after ss_n == 1 is seen in WAIT_END. spi_done rises one cycle later.
- Continuous mode: 1 IDLE cycle between frames.
- Reset asserted mid-frame: all state returns to reset values immediately. wren drops asynchronously.

## Test plan
- Reset, then start with mask 8'hFF, default banks: motor 0 receives Word 16'h8000 followed by 11 zero words; 12 acks complete the frame; frame_done pulses; cur_motor = 0.
- Mask 8'b1010_0100, continuous = 1: frames go to motors 2, 5, 7, 2 in that order; ss_n_o low only on the selected bit.
- Write cmd motor 3 index 1 = 16'd500, then run a frame to motor 3: Word sequence 8000, 01F4, 0, 0, 0; data_read values 1..12 → status[3][0..6] = 6..12.
- Set ACK_TIMEOUT = 16 and withhold write_ack after word 2: timeout_err[cur_motor] set at cycle 16; wren = 0; frame aborts after ss_n high. err_clr on that bit clears the flag.
- Assert reset_n low mid-frame, then release: wren = 0, spi_done = 1, command word 0 = 16'h8000, next frame goes to motor 0.
- Mask = 0 with start held high: stays in IDLE, spi_done = 1, no wren.
